ysyx_22040088_pcgen: RTL

YSYX_22040088_PCGEN -- requirements
Module: ysyx_22040088_pcgen

---
 rtl/ysyx_22040088_pkg.sv | 24 ++
 rtl/ysyx_22040088_btb.sv | 71 +++++++
 rtl/ysyx_22040088_pcgen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22040088_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_pkg
// Description : Shared definitions for the PC generator: FSM state encoding,
//               boot PC and sequential PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040088_pkg;

    // PC generator control states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } pcgen_state_e;

    // Boot PC used when the top-level parameter is left at its default
    localparam logic [63:0] c_reset_pc = 64'h0000_0000_8000_0000;

    // Sequential fetch step in bytes (one 32-bit instruction)
    localparam int unsigned c_pc_inc = 4;

endpackage : ysyx_22040088_pkg
`default_nettype wire

// File: rtl/ysyx_22040088_btb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_btb
// Description : Direct-mapped branch target buffer. Indexed by pc[2 +: IDXW],
//               tagged with the full PC, combinational lookup. Training
//               writes land at the clock edge, so a lookup in the same cycle
//               as an update still sees the old entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040088_btb #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // lookup port
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic [XLEN-1:0] target,
    // training port
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int c_idxw = $clog2(DEPTH);

    logic [DEPTH-1:0] r_valid;
    logic [XLEN-1:0]  r_tag    [DEPTH];
    logic [XLEN-1:0]  r_target [DEPTH];

    logic [c_idxw-1:0] w_lk_idx;
    logic [c_idxw-1:0] w_up_idx;
    logic              w_up_tag_match;

    // Instruction-aligned index: bits [1:0] are always zero for fetch PCs
    assign w_lk_idx = lookup_pc[2 +: c_idxw];
    assign w_up_idx = upd_pc[2 +: c_idxw];

    // Full-PC tag means no aliasing between PCs sharing an index
    assign hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == lookup_pc);
    assign target = r_target[w_lk_idx];

    // A not-taken resolution only invalidates the entry it actually owns
    assign w_up_tag_match = (r_tag[w_up_idx] == upd_pc);

    // Valid bits: cleared by reset, set on taken training, cleared on
    // not-taken training that matches the stored tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
            end else if (w_up_tag_match) begin
                r_valid[w_up_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload: no reset needed, qualified by the valid bit
    always_ff @(posedge clk) begin
        if (rst_n && upd_valid && upd_taken) begin
            r_tag[w_up_idx]    <= upd_pc;
            r_target[w_up_idx] <= upd_target;
        end
    end

endmodule : ysyx_22040088_btb
`default_nettype wire

// File: rtl/ysyx_22040088_pcgen.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_pcgen
// Description : Front-end PC generator. BOOT/RUN/FLUSH control, valid/ready
//               fetch handshake, priority-resolved redirects (highest source
//               index wins) and optional BTB-based next-PC prediction.
//               Optional feature macro: YSYX_22040088_BTB_EN - when defined,
//               a direct-mapped BTB (ysyx_22040088_btb) is instantiated;
//               otherwise fetch_pred_taken is tied low and training inputs
//               are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040088_pcgen
    import ysyx_22040088_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter int          NSRC      = 7,
    parameter logic [63:0] RESET_PC  = c_reset_pc,
    parameter int          BTB_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // redirect sources
    input  logic [NSRC-1:0]      redir_valid,
    input  logic [NSRC*XLEN-1:0] redir_pc,
    // backend stall
    input  logic                 stall,
    // fetch interface
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [XLEN-1:0]      fetch_pc,
    output logic                 fetch_pred_taken,
    // BTB training
    input  logic                 btb_upd_valid,
    input  logic [XLEN-1:0]      btb_upd_pc,
    input  logic [XLEN-1:0]      btb_upd_target,
    input  logic                 btb_upd_taken
);

    localparam logic [XLEN-1:0] c_boot_pc = XLEN'(RESET_PC);

    pcgen_state_e    r_state;
    pcgen_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;

    logic            w_redir_any;
    logic [XLEN-1:0] w_redir_tgt;
    logic            w_fire;
    logic [XLEN-1:0] w_seq_pc;
    logic            w_btb_hit;
    logic [XLEN-1:0] w_btb_target;

    // ------------------------------------------------------------------------
    // Redirect arbitration
    // ------------------------------------------------------------------------
    assign w_redir_any = |redir_valid;

    // Ascending scan: a later (higher-index) source overwrites earlier ones,
    // and the target is word-aligned by clearing bits [1:0]
    always_comb begin
        w_redir_tgt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (redir_valid[i]) begin
                w_redir_tgt = redir_pc[i*XLEN +: XLEN];
            end
        end
        w_redir_tgt[1:0] = 2'b00;
    end

    // ------------------------------------------------------------------------
    // Branch target buffer (optional)
    // ------------------------------------------------------------------------
`ifdef YSYX_22040088_BTB_EN
    ysyx_22040088_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_pc  (r_pc),
        .hit        (w_btb_hit),
        .target     (w_btb_target),
        .upd_valid  (btb_upd_valid),
        .upd_pc     (btb_upd_pc),
        .upd_target (btb_upd_target),
        .upd_taken  (btb_upd_taken)
    );
`else
    // No predictor: never taken, training port is a don't-care
    localparam int c_unused_btb_depth = BTB_DEPTH;
    logic          w_unused_btb;

    assign w_btb_hit    = 1'b0;
    assign w_btb_target = '0;
    assign w_unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
`endif

    // ------------------------------------------------------------------------
    // Fetch interface
    // ------------------------------------------------------------------------
    // Outputs are forced to their reset values whenever rst_n is low so the
    // fetch stage never sees a stale or unknown PC during reset
    assign fetch_valid      = rst_n && (r_state == ST_RUN) && !stall;
    assign fetch_pc         = rst_n ? r_pc : c_boot_pc;
    assign fetch_pred_taken = fetch_valid && w_btb_hit;

    assign w_fire   = fetch_valid && fetch_ready;
    assign w_seq_pc = fetch_pred_taken ? w_btb_target : (r_pc + XLEN'(c_pc_inc));

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // Next state / next PC: redirect beats handshake and stall; otherwise
    // BOOT and FLUSH last exactly one cycle and RUN advances on handshake
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (w_redir_any) begin
            w_state_nxt = ST_FLUSH;
            w_pc_nxt    = w_redir_tgt;
        end else begin
            unique case (r_state)
                ST_BOOT:  w_state_nxt = ST_RUN;
                ST_FLUSH: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_fire) begin
                        w_pc_nxt = w_seq_pc;
                    end
                end
                default:  w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // State and PC registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= c_boot_pc;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

endmodule : ysyx_22040088_pcgen
`default_nettype wire
